// File: rtl/router_pkg.sv
// Shared definitions for the router arbiter: FSM state encoding and
// default timing parameters.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_WIDTH       = 16;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: finds the first requester strictly
// after `last`, wrapping around, and reports whether anyone is requesting.
module rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] idx_s;

  // Scan from last+1 upward with wrap; the first hit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx_s  = '0;
    for (int i = 1; i <= N; i++) begin
      idx_s = IDX_W'((int'(last) + i) % N);
      if (!valid && req[idx_s]) begin
        valid  = 1'b1;
        winner = idx_s;
      end else begin
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/router_arbiter.sv
// Round-robin arbiter granting one of NUM_MASTERS masters access to a single
// slave port, with per-transaction ack/timeout reporting back to the master.
module router_arbiter
  import router_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              s_req,
  output logic                              s_we,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic                              s_ack,
  input  logic [DATA_WIDTH-1:0]             s_rdata
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  state_t                 state_r, state_s;
  logic [IDX_W-1:0]       last_r, last_s;
  logic [IDX_W-1:0]       win_r, win_s;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
  logic [NUM_MASTERS-1:0] gnt_r, gnt_s, ack_r, ack_s, err_r, err_s;
  logic [DATA_WIDTH-1:0]  rdata_r, rdata_s, swdata_r, swdata_s;
  logic [ADDR_WIDTH-1:0]  saddr_r, saddr_s;
  logic                   sreq_r, sreq_s, swe_r, swe_s;
  logic [IDX_W-1:0]       rr_win_s;
  logic                   rr_valid_s;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  rr_select #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rr_select (
    .req    (m_req),
    .last   (last_r),
    .winner (rr_win_s),
    .valid  (rr_valid_s)
  );

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_s  = state_r;
    last_s   = last_r;
    win_s    = win_r;
    cnt_s    = cnt_r;
    gnt_s    = '0;
    ack_s    = '0;
    err_s    = '0;
    rdata_s  = rdata_r;
    sreq_s   = 1'b0;
    swe_s    = swe_r;
    saddr_s  = saddr_r;
    swdata_s = swdata_r;
    case (state_r)
      IDLE: begin
        if (rr_valid_s) begin
          state_s  = BUSY;
          last_s   = rr_win_s;
          win_s    = rr_win_s;
          cnt_s    = '0;
          gnt_s    = onehot(rr_win_s);
          sreq_s   = 1'b1;
          swe_s    = m_we[rr_win_s];
          saddr_s  = m_addr[rr_win_s*ADDR_WIDTH +: ADDR_WIDTH];
          swdata_s = m_wdata[rr_win_s*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // An ack on the timeout cycle still counts as a normal completion.
        if (s_ack) begin
          state_s = DONE;
          ack_s   = onehot(win_r);
          rdata_s = s_rdata;
        end else if (cnt_r == CNT_WIDTH'(TIMEOUT)) begin
          state_s = DONE;
          err_s   = onehot(win_r);
        end else begin
          cnt_s  = cnt_r + 16'd1;
          gnt_s  = onehot(win_r);
          sreq_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      last_r   <= IDX_W'(NUM_MASTERS - 1);
      win_r    <= '0;
      cnt_r    <= '0;
      gnt_r    <= '0;
      ack_r    <= '0;
      err_r    <= '0;
      rdata_r  <= '0;
      sreq_r   <= 1'b0;
      swe_r    <= 1'b0;
      saddr_r  <= '0;
      swdata_r <= '0;
    end else begin
      state_r  <= state_s;
      last_r   <= last_s;
      win_r    <= win_s;
      cnt_r    <= cnt_s;
      gnt_r    <= gnt_s;
      ack_r    <= ack_s;
      err_r    <= err_s;
      rdata_r  <= rdata_s;
      sreq_r   <= sreq_s;
      swe_r    <= swe_s;
      saddr_r  <= saddr_s;
      swdata_r <= swdata_s;
    end
  end

  assign m_gnt   = gnt_r;
  assign m_ack   = ack_r;
  assign m_err   = err_r;
  assign m_rdata = rdata_r;
  assign s_req   = sreq_r;
  assign s_we    = swe_r;
  assign s_addr  = saddr_r;
  assign s_wdata = swdata_r;

endmodule

// File: tb/tb_router_arbiter.sv
// Directed self-checking bench for router_arbiter (4 masters, TIMEOUT=8).
module tb_router_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   m_req;
  logic [3:0]   m_we;
  logic [127:0] m_addr;
  logic [127:0] m_wdata;
  logic [3:0]   m_gnt;
  logic [3:0]   m_ack;
  logic [3:0]   m_err;
  logic [31:0]  m_rdata;
  logic         s_req;
  logic         s_we;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic         s_ack;
  logic [31:0]  s_rdata;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  router_arbiter #(
    .NUM_MASTERS (4),
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .TIMEOUT     (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_gnt   (m_gnt),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .s_req   (s_req),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_ack   (s_ack),
    .s_rdata (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one transaction: waits (bounded) for s_req, acks on the given BUSY cycle.
  task automatic txn(input int busy_cycles, input logic [31:0] rdata,
                     output logic [3:0] gnt, output logic [3:0] ack, output logic [3:0] err);
    int n;
    n = 0;
    while (!s_req && n < 20) begin
      tick();
      n++;
    end
    check_eq("txn_sreq", {63'd0, s_req}, 64'd1);
    gnt = m_gnt;
    repeat (busy_cycles - 1) tick();
    s_ack   = 1'b1;
    s_rdata = rdata;
    tick();
    ack   = m_ack;
    err   = m_err;
    s_ack = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] g, a, e;
    int n;
    rst     = 1'b1;
    m_req   = 4'b0000;
    m_we    = 4'b0000;
    s_ack   = 1'b0;
    s_rdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      m_addr[i*32 +: 32]  = 32'h0000_1000 * (i + 1);
      m_wdata[i*32 +: 32] = 32'hA5A5_0000 + i;
    end
    #1;
    check_eq("rst_sreq", {63'd0, s_req}, 64'd0);
    check_eq("rst_gnt", {60'd0, m_gnt}, 64'd0);
    check_eq("rst_rdata", {32'd0, m_rdata}, 64'd0);
    check_eq("rst_saddr", {32'd0, s_addr}, 64'd0);
    do_reset();

    // Single write from master 0, acked on the 3rd BUSY cycle
    m_req = 4'b0001;
    m_we  = 4'b0001;
    m_addr[31:0]  = 32'h0000_0100;
    m_wdata[31:0] = 32'hDEAD_BEEF;
    tick();
    check_eq("wr_sreq", {63'd0, s_req}, 64'd1);
    check_eq("wr_gnt", {60'd0, m_gnt}, 64'h1);
    check_eq("wr_swe", {63'd0, s_we}, 64'd1);
    check_eq("wr_saddr", {32'd0, s_addr}, 64'h100);
    check_eq("wr_swdata", {32'd0, s_wdata}, 64'hDEADBEEF);
    m_req = 4'b0000;
    tick();
    tick();
    check_eq("wr_busy3_sreq", {63'd0, s_req}, 64'd1);
    check_eq("wr_busy3_ack", {60'd0, m_ack}, 64'd0);
    s_ack   = 1'b1;
    s_rdata = 32'hCAFE_0001;
    tick();
    s_ack = 1'b0;
    check_eq("wr_ack", {60'd0, m_ack}, 64'h1);
    check_eq("wr_err", {60'd0, m_err}, 64'h0);
    check_eq("wr_done_sreq", {63'd0, s_req}, 64'd0);
    check_eq("wr_done_gnt", {60'd0, m_gnt}, 64'd0);
    check_eq("wr_rdata_cap", {32'd0, m_rdata}, 64'hCAFE0001);
    tick();
    check_eq("wr_ack_one_pulse", {60'd0, m_ack}, 64'h0);

    // Fairness from reset: 0,1,2,3 then wrap with only 0 and 3 requesting
    do_reset();
    m_req = 4'b1111;
    m_we  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      txn(1, 32'h0000_0000 + i, g, a, e);
      check_eq($sformatf("fair_gnt%0d", i), {60'd0, g}, 64'd1 << i);
      check_eq($sformatf("fair_ack%0d", i), {60'd0, a}, 64'd1 << i);
    end
    m_req = 4'b1001;
    txn(2, 32'h1, g, a, e);
    check_eq("wrap_gnt0", {60'd0, g}, 64'h1);
    txn(2, 32'h2, g, a, e);
    check_eq("wrap_gnt3", {60'd0, g}, 64'h8);
    check_eq("wrap_ack3", {60'd0, a}, 64'h8);
    check_eq("wrap_err3", {60'd0, e}, 64'h0);

    // Read from master 2
    m_req = 4'b0100;
    m_we  = 4'b0000;
    txn(2, 32'h1234_5678, g, a, e);
    m_req = 4'b0000;
    check_eq("rd_gnt", {60'd0, g}, 64'h4);
    check_eq("rd_ack", {60'd0, a}, 64'h4);
    check_eq("rd_rdata", {32'd0, m_rdata}, 64'h12345678);

    // s_ack while idle is ignored and rdata holds
    s_ack   = 1'b1;
    s_rdata = 32'h5555_AAAA;
    tick();
    tick();
    s_ack = 1'b0;
    check_eq("idle_ack_ignored", {60'd0, m_ack}, 64'h0);
    check_eq("rdata_hold", {32'd0, m_rdata}, 64'h12345678);
    check_eq("idle_no_sreq", {63'd0, s_req}, 64'd0);

    // Timeout on master 1: err 9 cycles after s_req rises
    m_req = 4'b0010;
    tick();
    check_eq("to_sreq", {63'd0, s_req}, 64'd1);
    m_req = 4'b0000;
    n = 0;
    while (m_err == 4'b0000 && n < 30) begin
      tick();
      n++;
    end
    check_eq("to_latency", 64'(n), 64'd9);
    check_eq("to_err", {60'd0, m_err}, 64'h2);
    check_eq("to_ack", {60'd0, m_ack}, 64'h0);
    tick();
    check_eq("to_err_pulse", {60'd0, m_err}, 64'h0);
    check_eq("to_idle_sreq", {63'd0, s_req}, 64'd0);

    // Reset mid-BUSY aborts silently; next grant goes to master 0
    m_req = 4'b1000;
    m_we  = 4'b1000;
    tick();
    check_eq("rb_sreq", {63'd0, s_req}, 64'd1);
    check_eq("rb_gnt", {60'd0, m_gnt}, 64'h8);
    rst = 1'b1;
    #1;
    check_eq("rb_sreq_async", {63'd0, s_req}, 64'd0);
    check_eq("rb_gnt_async", {60'd0, m_gnt}, 64'h0);
    check_eq("rb_saddr_async", {32'd0, s_addr}, 64'h0);
    check_eq("rb_rdata_async", {32'd0, m_rdata}, 64'h0);
    tick();
    rst   = 1'b0;
    m_req = 4'b0000;
    tick();
    check_eq("rb_no_ack", {60'd0, m_ack}, 64'h0);
    check_eq("rb_no_err", {60'd0, m_err}, 64'h0);
    m_req = 4'b1111;
    txn(1, 32'h7, g, a, e);
    check_eq("rb_next_gnt", {60'd0, g}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule

// File: doc/router_arbiter.md
ROUTER_ARBITER -- requirements
Module: router_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max cycles waiting for slave ack (1..65535).
REQ-005 SHALL have ports:
  - clk  in  1  single clock, all state on rising edge.
  - rst  in  1  asynchronous, active-high reset.
  - m_req  in  NUM_MASTERS  per-master transaction request.
  - m_we  in  NUM_MASTERS  per-master write enable (1 = write).
  - m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at slice i.
  - m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data, master i at slice i.
  - m_gnt  out  NUM_MASTERS  one-hot grant.
  - m_ack  out  NUM_MASTERS  one-cycle completion pulse.
  - m_err  out  NUM_MASTERS  one-cycle timeout pulse.
  - m_rdata  out  DATA_WIDTH  read data, valid with m_ack.
  - s_req  out  1  slave request.
  - s_we  out  1  slave write enable.
  - s_addr  out  ADDR_WIDTH  slave address.
  - s_wdata  out  DATA_WIDTH  slave write data.
  - s_ack  in  1  slave completion.
  - s_rdata  in  DATA_WIDTH  slave read data, sampled with s_ack.

Function
REQ-006 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-007 IDLE: if any m_req high, SHALL select winner round-robin, searching from (last_grant+1) mod NUM_MASTERS upward with wrap; go to BUSY next cycle; else stay IDLE.
REQ-008 On selection, SHALL register winner index, its m_we, m_addr, m_wdata; update last_grant to winner.
REQ-009 BUSY: SHALL drive s_req=1, s_we/s_addr/s_wdata from registered values, m_gnt one-hot on winner.
REQ-010 BUSY with s_ack=1: SHALL capture s_rdata into m_rdata, go DONE, set ack flag.
REQ-011 BUSY: SHALL count cycles from 0; counter reaching TIMEOUT with s_ack=0 SHALL go DONE, set err flag; s_ack on that same cycle wins (ack, not err).
REQ-012 DONE: SHALL pulse m_ack[winner] (or m_err[winner]) for exactly one cycle, s_req=0, m_gnt=0; go IDLE next cycle.
REQ-013 Latency: m_req seen in IDLE at cycle 0 -> s_req at cycle 1; s_ack at cycle k -> m_ack at k+1; IDLE at k+2.
REQ-014 Deassertion of m_req[winner] during BUSY SHALL be ignored; transaction completes normally.
REQ-015 s_ack outside BUSY SHALL be ignored.
REQ-016 At most one bit of m_gnt, m_ack, m_err SHALL be high in any cycle; m_ack and m_err never together.
REQ-017 m_rdata SHALL hold last captured value until next capture; write transactions also capture s_rdata.

Reset
REQ-018 rst high SHALL immediately force: state IDLE, m_gnt=0, m_ack=0, m_err=0, m_rdata=0, s_req=0, s_we=0, s_addr=0, s_wdata=0, counter=0, last_grant=NUM_MASTERS-1 (first search starts at master 0).
REQ-019 Reset during BUSY SHALL abort the transaction with no m_ack/m_err pulse.

Structure
REQ-020 State enum (IDLE/BUSY/DONE) and TIMEOUT default SHALL live in shared package router_pkg.
REQ-021 Round-robin priority selection SHALL be a sub-module rr_select (inputs req vector, last index; output winner index, valid), purely combinational.

Verification
REQ-022 Single write: m_req=4'b0001, we=1, addr=0x100, wdata=0xDEADBEEF; s_ack at 3rd BUSY cycle -> s_addr=0x100, s_wdata=0xDEADBEEF, m_ack[0] one pulse, m_err=0.
REQ-023 Fairness: m_req=4'b1111 held -> grant order 0,1,2,3,0; each m_ack once per round.
REQ-024 Wrap: after grant to 3, m_req=4'b1001 -> next grant 0, then 3.
REQ-025 Timeout: TIMEOUT=8, s_ack never -> m_err[winner] pulse 9 cycles after s_req rises, m_ack=0, FSM back to IDLE.
REQ-026 Read: m_req[2], we=0, s_rdata=0x12345678 with s_ack -> m_rdata=0x12345678 with m_ack[2].
REQ-027 Reset mid-BUSY: assert rst -> all outputs 0 same cycle, no ack/err, next grant after release is master 0.
